fw_ram_ctrl: RTL and testbench

//   Sits between the CPU memory bus and the 256 x 32 FW RAM and owns every access to it.
//   In firmware mode CPU accesses pass through. In app mode they are denied: reads return 0,

---
 rtl/fw_ram_ctrl_pkg.sv | 23 ++
 rtl/fw_ram_ctrl_wiper.sv | 36 +++
 rtl/fw_ram_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fw_ram_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fw_ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fw_ram_ctrl_pkg
// Description : Shared constants for the FW RAM access controller: RAM
//               geometry and the controller FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fw_ram_ctrl_pkg;

    // FW RAM geometry
    localparam int FW_RAM_ADDR_WIDTH = 8;
    localparam int FW_RAM_WORDS      = 2 ** FW_RAM_ADDR_WIDTH;
    localparam int FW_RAM_DATA_WIDTH = 32;

    // Controller FSM state encodings
    localparam int                  ST_WIDTH  = 2;
    localparam logic [ST_WIDTH-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_WIDTH-1:0] ST_ACCESS = 2'd1;
    localparam logic [ST_WIDTH-1:0] ST_DENY   = 2'd2;
    localparam logic [ST_WIDTH-1:0] ST_WIPE   = 2'd3;

endpackage : fw_ram_ctrl_pkg
`default_nettype wire

// File: rtl/fw_ram_ctrl_wiper.sv
`default_nettype none
// ============================================================================
// Module      : fw_ram_ctrl_wiper
// Description : Wipe address counter. Advances one word per cycle while
//               run_i is high and flags the last word of the RAM. The
//               counter wraps to zero naturally after the last word.
// Revision    : 1.0 - initial release
// ============================================================================
module fw_ram_ctrl_wiper #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o
);

    localparam logic [ADDR_WIDTH-1:0] C_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] cnt_q;

    // Word counter: one step per wipe cycle, wraps to 0 after the last word
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (run_i) begin
            cnt_q <= cnt_q + C_ONE;
        end
    end

    assign addr_o = cnt_q;
    assign last_o = (cnt_q == {ADDR_WIDTH{1'b1}});

endmodule : fw_ram_ctrl_wiper
`default_nettype wire

// File: rtl/fw_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fw_ram_ctrl
// Description : Owns every access to the FW RAM. Firmware-mode CPU accesses
//               pass through; app-mode accesses are answered locally (reads
//               return 0, writes dropped). A wipe sequencer overwrites the
//               whole RAM on app-mode entry, firmware zeroize, or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module fw_ram_ctrl
    import fw_ram_ctrl_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = FW_RAM_ADDR_WIDTH,
    parameter int                    DATA_WIDTH    = FW_RAM_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] WIPE_PATTERN  = '0,
    parameter bit                    WIPE_ON_RESET = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fw_app_mode,
    input  logic                    zeroize,
    input  logic                    cpu_cs,
    input  logic [DATA_WIDTH/8-1:0] cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_address,
    input  logic [DATA_WIDTH-1:0]   cpu_write_data,
    output logic [DATA_WIDTH-1:0]   cpu_read_data,
    output logic                    cpu_ready,
    output logic                    ram_cs,
    output logic [DATA_WIDTH/8-1:0] ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic [DATA_WIDTH-1:0]   ram_write_data,
    input  logic [DATA_WIDTH-1:0]   ram_read_data,
    input  logic                    ram_ready,
    output logic                    wipe_busy
);

    logic [ST_WIDTH-1:0]   state_q;
    logic [ST_WIDTH-1:0]   state_d;
    logic [ST_WIDTH-1:0]   cur_state;
    logic                  boot_q;
    logic                  app_mode_q;
    logic                  pending_q;
    logic                  pending_d;
    logic                  trigger;
    logic                  wipe_last;
    logic [ADDR_WIDTH-1:0] wipe_addr;

    // boot_q marks the first cycle after reset. The register itself holds
    // IDLE through reset; the reset-time wipe is injected here so that the
    // wipe occupies that very first cycle with the counter already at 0.
    assign cur_state = (boot_q && WIPE_ON_RESET) ? ST_WIPE : state_q;

    // Rising edge of app mode, or a zeroize that only firmware may issue
    assign trigger = (fw_app_mode && !app_mode_q) || (zeroize && !fw_app_mode);

    fw_ram_ctrl_wiper #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wiper (
        .clk    (clk),
        .reset  (reset),
        .run_i  (cur_state == ST_WIPE),
        .addr_o (wipe_addr),
        .last_o (wipe_last)
    );

    // State register plus trigger bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            boot_q     <= 1'b1;
            app_mode_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_q     <= 1'b0;
            app_mode_q <= fw_app_mode;
            pending_q  <= pending_d;
        end
    end

    // Next state: a wipe always wins over a new CPU request in IDLE; a
    // trigger seen mid-access is parked in pending until the access ends.
    always_comb begin
        state_d   = cur_state;
        pending_d = pending_q;
        case (cur_state)
            ST_IDLE: begin
                if (pending_q || trigger) begin
                    state_d = ST_WIPE;
                end else if (cpu_cs) begin
                    state_d = fw_app_mode ? ST_DENY : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ram_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DENY: begin
                state_d = ST_IDLE;
            end
            ST_WIPE: begin
                if (wipe_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Triggers during a wipe merge into it; entering WIPE consumes pending
        if (cur_state != ST_WIPE) begin
            if (state_d == ST_WIPE) begin
                pending_d = 1'b0;
            end else if (trigger) begin
                pending_d = 1'b1;
            end
        end
    end

    // Outputs: RAM/CPU mux per state, all forced low while reset is held
    always_comb begin
        cpu_read_data  = '0;
        cpu_ready      = 1'b0;
        ram_cs         = 1'b0;
        ram_we         = '0;
        ram_address    = '0;
        ram_write_data = '0;
        wipe_busy      = 1'b0;
        if (!reset) begin
            case (cur_state)
                ST_IDLE: begin
                    if (!pending_q && !trigger && cpu_cs && !fw_app_mode) begin
                        ram_cs         = 1'b1;
                        ram_we         = cpu_we;
                        ram_address    = cpu_address;
                        ram_write_data = cpu_write_data;
                    end
                end
                ST_ACCESS: begin
                    cpu_ready     = ram_ready;
                    cpu_read_data = ram_ready ? ram_read_data : '0;
                end
                ST_DENY: begin
                    cpu_ready = 1'b1;
                end
                ST_WIPE: begin
                    ram_cs         = 1'b1;
                    ram_we         = '1;
                    ram_address    = wipe_addr;
                    ram_write_data = WIPE_PATTERN;
                    wipe_busy      = 1'b1;
                end
                default: begin
                    cpu_ready = 1'b0;
                end
            endcase
        end
    end

endmodule : fw_ram_ctrl
`default_nettype wire

// File: tb/tb_fw_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fw_ram_ctrl
// Description : Self-checking bench for fw_ram_ctrl. Two controllers share
//               the CPU-side stimulus: u_dut1 wipes on reset, u_dut0 does
//               not. Each drives its own behavioural 256 x 32 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fw_ram_ctrl;
    import fw_ram_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fw_app_mode = 1'b0;
    logic        zeroize = 1'b0;
    logic        cpu_cs = 1'b0;
    logic [3:0]  cpu_we = 4'h0;
    logic [7:0]  cpu_address = 8'h0;
    logic [31:0] cpu_write_data = 32'h0;
    logic        fill = 1'b1;

    logic [31:0] cpu_read_data1, ram_write_data1, rd1;
    logic        cpu_ready1, ram_cs1, wipe_busy1, rdy1;
    logic [3:0]  ram_we1;
    logic [7:0]  ram_address1;
    logic [31:0] cpu_read_data0, ram_write_data0, rd0;
    logic        cpu_ready0, ram_cs0, wipe_busy0, rdy0;
    logic [3:0]  ram_we0;
    logic [7:0]  ram_address0;

    logic [31:0] mem1 [0:FW_RAM_WORDS-1];
    logic [31:0] mem0 [0:FW_RAM_WORDS-1];

    int n_checks = 0;
    int n_errors = 0;
    int cs_cnt1 = 0;
    int we_cnt1 = 0;

    always #5 clk = ~clk;

    fw_ram_ctrl #(.WIPE_ON_RESET(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .fw_app_mode(fw_app_mode), .zeroize(zeroize),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data1),
        .cpu_ready(cpu_ready1), .ram_cs(ram_cs1), .ram_we(ram_we1),
        .ram_address(ram_address1), .ram_write_data(ram_write_data1),
        .ram_read_data(rd1), .ram_ready(rdy1), .wipe_busy(wipe_busy1)
    );

    fw_ram_ctrl #(.WIPE_ON_RESET(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .fw_app_mode(fw_app_mode), .zeroize(zeroize),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_address(cpu_address),
        .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data0),
        .cpu_ready(cpu_ready0), .ram_cs(ram_cs0), .ram_we(ram_we0),
        .ram_address(ram_address0), .ram_write_data(ram_write_data0),
        .ram_read_data(rd0), .ram_ready(rdy0), .wipe_busy(wipe_busy0)
    );

    // RAM models: ready one cycle after cs, byte-enabled writes, old-data reads
    always @(posedge clk) begin
        rdy1 <= ram_cs1;
        rdy0 <= ram_cs0;
        if (fill) begin
            for (int i = 0; i < FW_RAM_WORDS; i++) begin
                mem1[i] <= 32'hA5A5_0000 | 32'(i);
                mem0[i] <= 32'h5A5A_0000 | 32'(i);
            end
        end else begin
            if (ram_cs1) begin
                rd1 <= mem1[ram_address1];
                for (int b = 0; b < 4; b++)
                    if (ram_we1[b]) mem1[ram_address1][b*8 +: 8] <= ram_write_data1[b*8 +: 8];
            end
            if (ram_cs0) begin
                rd0 <= mem0[ram_address0];
                for (int b = 0; b < 4; b++)
                    if (ram_we0[b]) mem0[ram_address0][b*8 +: 8] <= ram_write_data0[b*8 +: 8];
            end
        end
    end

    // Count RAM selects / writes on u_dut1 that do not belong to a wipe
    always @(negedge clk) begin
        if (ram_cs1 && !wipe_busy1) cs_cnt1 <= cs_cnt1 + 1;
        if (ram_cs1 && !wipe_busy1 && ram_we1 != 4'h0) we_cnt1 <= we_cnt1 + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        logic any;
        any = |{cpu_read_data1, cpu_ready1, ram_cs1, ram_we1, ram_address1, ram_write_data1, wipe_busy1,
                cpu_read_data0, cpu_ready0, ram_cs0, ram_we0, ram_address0, ram_write_data0, wipe_busy0};
        check(name, {31'h0, any}, 32'h0);
    endtask

    // One CPU transaction; lat = cycles from cs to cpu_ready (0 on timeout)
    task automatic cpu_xfer(input bit which, input logic [3:0] we, input logic [7:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output int lat);
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_we = we; cpu_address = addr; cpu_write_data = wd;
        lat = 0;
        rd  = 32'h0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (which ? cpu_ready1 : cpu_ready0) begin
                lat = n;
                rd  = which ? cpu_read_data1 : cpu_read_data0;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_cs = 1'b0; cpu_we = 4'h0;
    endtask

    // Follow one u_dut1 wipe: wait_cyc = idle cycles before it starts.
    // zero_at pulses zeroize after that many wipe cycles; abort_at asserts reset.
    task automatic run_wipe(input string name, input int zero_at, input int abort_at,
                            output int wait_cyc);
        bit started;
        int len;
        int bad;
        started  = 1'b0;
        len      = 0;
        bad      = 0;
        wait_cyc = 0;
        for (int i = 0; i < 20 && !started; i++) begin
            @(negedge clk);
            if (wipe_busy1) started = 1'b1;
            else wait_cyc++;
        end
        check({name, "_started"}, {31'h0, started}, 32'h1);
        while (started && wipe_busy1 && len < 300) begin
            if (!(ram_cs1 && ram_we1 == 4'hf && ram_address1 == len[7:0] && ram_write_data1 == 32'h0))
                bad++;
            len++;
            @(posedge clk); #1;
            zeroize = (len == zero_at);
            if (len == abort_at) begin
                reset = 1'b1;
                break;
            end
            @(negedge clk);
        end
        zeroize = 1'b0;
        check({name, "_seq"}, 32'(bad), 32'h0);
        if (abort_at < 0) check({name, "_len"}, 32'(len), 32'd256);
    endtask

    typedef struct {
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [31:0] wd;
        bit          rd_chk;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] rd;
    int          lat;
    int          w;
    int          cnt;
    int          cs_snap;
    int          we_snap;

    initial begin
        tbl[0] = '{4'hf, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1] = '{4'h0, 8'h10, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[2] = '{4'h2, 8'h10, 32'h0000AB00, 1'b0, 32'h0};
        tbl[3] = '{4'h0, 8'h10, 32'h0,        1'b1, 32'hDEADABEF};
        tbl[4] = '{4'hf, 8'h11, 32'h11223344, 1'b0, 32'h0};
        tbl[5] = '{4'h1, 8'h11, 32'h000000CC, 1'b0, 32'h0};
        tbl[6] = '{4'hc, 8'h11, 32'h55660000, 1'b0, 32'h0};
        tbl[7] = '{4'h0, 8'h11, 32'h0,        1'b1, 32'h556633CC};

        // Test 1: reset, outputs quiet, then a full wipe starting immediately
        repeat (2) @(posedge clk);
        #1 fill = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_outputs_zero("t1_reset_outputs");
        end
        @(posedge clk); #1 reset = 1'b0;
        run_wipe("t1_wipe", -1, -1, w);
        check("t1_wipe_first_cycle", 32'(w), 32'h0);
        cnt = 0;
        for (int a = 0; a < FW_RAM_WORDS; a++) begin
            cpu_xfer(1'b1, 4'h0, a[7:0], 32'h0, rd, lat);
            if (rd != 32'h0 || lat != 1) cnt++;
        end
        check("t1_ram_all_zero", 32'(cnt), 32'h0);

        // Test 2: firmware-mode pass-through from the vector table
        for (int i = 0; i < 8; i++) begin
            cpu_xfer(1'b1, tbl[i].we, tbl[i].addr, tbl[i].wd, rd, lat);
            check($sformatf("t2_lat_%0d", i), 32'(lat), 32'h1);
            if (tbl[i].rd_chk) check($sformatf("t2_rdata_%0d", i), rd, tbl[i].exp_rd);
        end

        // Test 3: entering app mode wipes, then reads are denied without RAM access
        @(posedge clk); #1 fw_app_mode = 1'b1;
        run_wipe("t3_wipe", -1, -1, w);
        check("t3_wipe_start", 32'(w), 32'h1);
        check("t3_mem_wiped", mem1[8'h10], 32'h0);
        cs_snap = cs_cnt1;
        we_snap = we_cnt1;
        cpu_xfer(1'b1, 4'h0, 8'h10, 32'h0, rd, lat);
        check("t3_deny_lat", 32'(lat), 32'h1);
        check("t3_deny_rdata", rd, 32'h0);
        check("t3_no_ram_cs", 32'(cs_cnt1 - cs_snap), 32'h0);

        // Test 4: app-mode write dropped; zeroize ignored
        cpu_xfer(1'b1, 4'hf, 8'h20, 32'h12345678, rd, lat);
        check("t4_deny_wr_lat", 32'(lat), 32'h1);
        check("t4_no_ram_we", 32'(we_cnt1 - we_snap), 32'h0);
        check("t4_mem_untouched", mem1[8'h20], 32'h0);
        @(posedge clk); #1 zeroize = 1'b1;
        @(posedge clk); #1 zeroize = 1'b0;
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (wipe_busy1) cnt++;
        end
        check("t4_zeroize_ignored", 32'(cnt), 32'h0);

        // Test 5: back to firmware mode; zeroize during an access
        @(posedge clk); #1 reset = 1'b1; fw_app_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_wipe("t5_boot_wipe", -1, -1, w);
        cpu_xfer(1'b1, 4'hf, 8'h40, 32'hCAFEF00D, rd, lat);
        check("t5_wr_lat", 32'(lat), 32'h1);
        @(posedge clk); #1;
        cpu_cs = 1'b1; cpu_we = 4'h0; cpu_address = 8'h40;
        @(posedge clk); #1 zeroize = 1'b1;
        @(negedge clk);
        check("t5_access_ready", {31'h0, cpu_ready1}, 32'h1);
        check("t5_access_rdata", cpu_read_data1, 32'hCAFEF00D);
        check("t5_no_wipe_yet", {31'h0, wipe_busy1}, 32'h0);
        @(posedge clk); #1 zeroize = 1'b0; cpu_cs = 1'b0;
        run_wipe("t5_wipe", 120, -1, w);
        check("t5_wipe_after_idle", 32'(w), 32'h1);
        check("t5_mem_wiped", mem1[8'h40], 32'h0);

        // Test 6: reset at wipe cycle 100; the no-wipe-on-reset controller serves at once
        @(posedge clk); #1 zeroize = 1'b1;
        @(posedge clk); #1 zeroize = 1'b0;
        run_wipe("t6_wipe", -1, 100, w);
        repeat (3) begin
            @(negedge clk);
            check_outputs_zero("t6_reset_outputs");
        end
        @(posedge clk); #1 reset = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (wipe_busy0) cnt++;
        end
        check("t6_no_boot_wipe", 32'(cnt), 32'h0);
        cpu_xfer(1'b0, 4'hf, 8'h30, 32'h0A0B0C0D, rd, lat);
        check("t6_wr_lat", 32'(lat), 32'h1);
        cpu_xfer(1'b0, 4'h0, 8'h30, 32'h0, rd, lat);
        check("t6_rd_lat", 32'(lat), 32'h1);
        check("t6_rd_data", rd, 32'h0A0B0C0D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_fw_ram_ctrl
`default_nettype wire
